// File: rtl/pc_buffer.sv
// Fixed-latency history buffer for the voted PC/instruction stream.
// PC_Top_rollback shows the word captured on PC_Top exactly DEPTH rising edges earlier.
module pc_buffer #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] PC_Top,
    output logic [WIDTH-1:0] PC_Top_rollback
);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("pc_buffer: DEPTH must be in 1..16");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // The chain shifts unconditionally; any freezing during hold/recovery is
    // up to the controller, so there is deliberately no enable here.
    assign stage_d[0] = PC_Top;
    for (genvar i = 1; i < DEPTH; i++) begin : g_chain
        assign stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '{default: RESET_VALUE};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign PC_Top_rollback = stage_q[DEPTH-1];

endmodule

// File: tb/tb_pc_buffer.sv
// Self-checking bench for pc_buffer: a DEPTH=4 and a DEPTH=1 build checked
// against a queue of captured words (output = word captured DEPTH edges ago).
module tb_pc_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_top;
    logic [31:0] pc_top1;
    logic [31:0] out4;
    logic [31:0] out1;

    int total;
    int bad;

    logic [31:0] cap_q[$];
    logic [31:0] cap1_q[$];

    pc_buffer #(.WIDTH(32), .DEPTH(4), .RESET_VALUE(32'h0000_0000)) u_dut4 (
        .clk(clk),
        .rst_n(rst_n),
        .PC_Top(pc_top),
        .PC_Top_rollback(out4)
    );

    pc_buffer #(.WIDTH(32), .DEPTH(1), .RESET_VALUE(32'h0000_0000)) u_dut1 (
        .clk(clk),
        .rst_n(rst_n),
        .PC_Top(pc_top1),
        .PC_Top_rollback(out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected output: the word captured DEPTH edges ago, or the reset value
    // when fewer than DEPTH captures have happened since reset.
    function automatic logic [31:0] exp4();
        if (cap_q.size() < 4) return 32'h0;
        return cap_q[cap_q.size() - 4];
    endfunction

    function automatic logic [31:0] exp1();
        if (cap1_q.size() < 1) return 32'h0;
        return cap1_q[cap1_q.size() - 1];
    endfunction

    task automatic model_clear();
        cap_q.delete();
        cap1_q.delete();
    endtask

    // Drive on the falling edge, let the rising edge capture, return 1 ns later.
    task automatic step(input logic [31:0] d, input logic [31:0] d1);
        @(negedge clk);
        pc_top  = d;
        pc_top1 = d1;
        @(posedge clk);
        if (rst_n) begin
            cap_q.push_back(d);
            cap1_q.push_back(d1);
            if (cap_q.size() > 16) void'(cap_q.pop_front());
            if (cap1_q.size() > 16) void'(cap1_q.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (out4 !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", out4, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step($urandom, $urandom);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        total++;
        if (out4 !== 32'h0 || out1 !== 32'h0) begin
            bad++;
            $display("FAIL reset_async: got %h/%h want 0/0", out4, out1);
        end
        for (int i = 0; i < 5; i++) begin
            step($urandom, $urandom);
            total++;
            if (out4 !== 32'h0 || out1 !== 32'h0) begin
                bad++;
                $display("FAIL reset_hold edge %0d: got %h/%h want 0/0", i, out4, out1);
            end
        end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_delay();
        for (int i = 1; i <= 12; i++) begin
            step(32'(i), $urandom);
            total++;
            if (out4 !== exp4()) begin
                bad++;
                $display("FAIL delay edge %0d: got %h want %h", i, out4, exp4());
            end
            total++;
            if (out4 !== ((i < 4) ? 32'h0 : 32'(i - 3))) begin
                bad++;
                $display("FAIL delay_abs edge %0d: got %h want %h", i, out4,
                         (i < 4) ? 32'h0 : 32'(i - 3));
            end
        end
    endtask

    task automatic test_full_width();
        logic [31:0] vals [3];
        vals[0] = 32'h0020A083;
        vals[1] = 32'hFFFFFFFF;
        vals[2] = 32'h80000000;
        for (int i = 0; i < 7; i++) begin
            step((i < 3) ? vals[i] : $urandom, $urandom);
            total++;
            if (out4 !== exp4()) begin
                bad++;
                $display("FAIL full_width edge %0d: got %h want %h", i, out4, exp4());
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) step(32'hA5A5A5A5, 32'hA5A5A5A5);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        total++;
        if (out4 !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_async: got %h want %h", out4, 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(32'h12345678, 32'h12345678);
            total++;
            if (out4 !== exp4() || out4 === 32'hA5A5A5A5) begin
                bad++;
                $display("FAIL mid_reset edge %0d: got %h want %h", i, out4, exp4());
            end
            total++;
            if (out4 !== ((i < 4) ? 32'h0 : 32'h12345678)) begin
                bad++;
                $display("FAIL mid_reset_abs edge %0d: got %h want %h", i, out4,
                         (i < 4) ? 32'h0 : 32'h12345678);
            end
        end
    endtask

    task automatic test_depth1();
        step($urandom, 32'hDEADBEEF);
        total++;
        if (out1 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL depth1_capture: got %h want %h", out1, 32'hDEADBEEF);
        end
        #3;
        pc_top1 = 32'h0BADF00D;
        #1;
        total++;
        if (out1 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL depth1_hold: got %h want %h", out1, 32'hDEADBEEF);
        end
        step($urandom, 32'h0BADF00D);
        total++;
        if (out1 !== exp1()) begin
            bad++;
            $display("FAIL depth1_next: got %h want %h", out1, exp1());
        end
    endtask

    task automatic test_held();
        for (int i = 0; i < 10; i++) step(32'h00000123, $urandom);
        total++;
        if (out4 !== 32'h00000123) begin
            bad++;
            $display("FAIL held_steady: got %h want %h", out4, 32'h00000123);
        end
        for (int i = 1; i <= 6; i++) begin
            step(32'h00000456, $urandom);
            total++;
            if (out4 !== exp4() || out4 !== ((i < 4) ? 32'h00000123 : 32'h00000456)) begin
                bad++;
                $display("FAIL held_change edge %0d: got %h want %h", i, out4, exp4());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step($urandom, $urandom);
            total++;
            if (out4 !== exp4() || out1 !== exp1()) begin
                bad++;
                $display("FAIL random edge %0d: got %h/%h want %h/%h",
                         i, out4, out1, exp4(), exp1());
            end
            if ($urandom_range(0, 39) == 0) begin
                #2;
                rst_n = 1'b0;
                model_clear();
                #1;
                total++;
                if (out4 !== 32'h0 || out1 !== 32'h0) begin
                    bad++;
                    $display("FAIL random_reset edge %0d: got %h/%h want 0/0", i, out4, out1);
                end
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        pc_top  = '0;
        pc_top1 = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_delay();
        test_full_width();
        test_mid_reset();
        test_depth1();
        test_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
